mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences the single byte-wide RAM/UART bus (mem_din/mem_dout/mem_a/mem_wr) between two requesters: the instruction cache (32-bit fetches) and the load/store buffer (1/2/4-byte loads and stores).
- Sits between ICache/LSB and the hci/ram interface.
- Splits each word access into byte beats and assembles read data little-endian.
- Honours UART back-pressure, pipeline flush (clr) and rdy stalls.
- Arbitrates with LSB priority, bounded by an ICache anti-starvation counter.

Parameters:
STARVE_LIMIT, 4, consecutive ICache losses after which ICache wins the next arbitration
IO_GAP, 1, idle cycles inserted after every write to I/O space (mem_a[17:16]==2'b11)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rdy  in  1  when low, freeze all state and force mem_wr=0
clr  in  1  flush; aborts in-flight ICache/LSB-load transactions
io_buffer_full  in  1  UART tx buffer full
mem_din  in  8  read data, valid one cycle after the address
mem_dout  out  8  write data
mem_a  out  32  byte address
mem_wr  out  1  1=write
IC_S  in  1  ICache request, level, held until IC_success
IC_pos  in  32  fetch address, word aligned
IC_success  out  1  one-cycle pulse, IC_value valid
IC_value  out  32  fetched instruction
LSB_S  in  1  LSB request, level, held until LSB_success
LSB_type  in  1  1=store, 0=load
LSB_pos  in  32  byte address
LSB_len  in  3  byte count: 1, 2 or 4
LSB_result  in  32  store data, low LSB_len bytes used
LSB_success  out  1  one-cycle pulse
LSB_value  out  32  load data, zero-extended; the LSB sign-extends

Behaviour:
- Reset values: mem_a=0, mem_dout=0, mem_wr=0, IC_success=0, LSB_success=0, IC_value=0, LSB_value=0. State=IDLE, starve counter=0.
- States: IDLE, READ, WRITE, DONE, IOWAIT.
- Grant decision in IDLE, registered on the clock edge. Ignore any requester whose success pulse is asserted in the same cycle.
- Winner is LSB if LSB_S, unless IC_S and starve==STARVE_LIMIT, in which case ICache wins.
- Starve counter: increments (saturating) when IC_S loses a grant, clears when ICache is granted.
- Request fields (addr, len, data, type) are latched at grant. Later changes on the inputs are ignored.
- READ of N bytes (ICache N=4):
  - Cycles 1..N drive mem_a=addr+k (k=0..N-1) with mem_wr=0.
  - Byte k is captured from mem_din in cycle k+2 into bits [8k+7:8k].
  - Success pulses in cycle N+2 after grant, with the value registered.
  - Unused upper bytes read as 0.
- WRITE of N bytes:
  - Cycles 1..N drive mem_a=addr+k, mem_dout=data[8k+7:8k], mem_wr=1.
  - LSB_success pulses in cycle N+1.
- I/O write (latched addr[17:16]==2'b11):
  - Before each beat, if io_buffer_full=1, hold that beat with mem_wr=0 and no address advance.
  - After the last beat, enter IOWAIT for IO_GAP cycles before DONE.
- I/O read: behaves as a normal READ.
- DONE: one cycle, success pulse, mem_wr=0, returns to IDLE. Minimum gap between transactions is one cycle.
- clr=1 during READ (either requester) or in IDLE:
  - Next state is IDLE.
  - No success pulse.
  - Captured data is discarded and mem_wr=0.
  - Starve counter is unchanged.
- clr does not abort a WRITE: stores are already committed and must finish and pulse LSB_success.
- clr in DONE of a READ: the pulse is suppressed.
- rdy=0: state, counters, mem_a and mem_dout hold; mem_wr=0. On resume, a read beat whose address was driven before the stall is re-issued, because mem_din is not trusted across a stall.
- Address arithmetic is 32-bit wrapping; there is no alignment check.
- Simultaneous IC_S and LSB_S with starve<STARVE_LIMIT: LSB wins.
- Reset mid-transaction: immediate return to reset values, no pulses.

Test Plan:
- ICache fetch alone, IC_pos=0x100, RAM bytes 13,00,00,00: mem_a=0x100..0x103 in cycles 1-4, IC_success in cycle 6, IC_value=0x00000013.
- LSB sw of 0xDEADBEEF to 0x200: beats EF,BE,AD,DE with mem_wr=1 at 0x200..0x203, LSB_success in cycle 5. Then lh from 0x202 returns LSB_value=0x0000DEAD.
- IC_S and LSB_S both held continuously with back-to-back LSB loads: LSB granted 4 times, ICache granted on the 5th arbitration, starve counter returns to 0.
- sb of 0x41 to 0x30000 with io_buffer_full high for 3 cycles: mem_wr stays 0 for those 3 cycles, then 1 beat is written, 1 IOWAIT cycle, then LSB_success.
- clr asserted in cycle 2 of an ICache fetch: no IC_success, IDLE next cycle. clr during a 4-byte store: all 4 beats still written and LSB_success pulses.
- rdy dropped for 2 cycles mid-load of 4 bytes from 0x300: mem_wr=0 and addresses hold during the stall; after resume the correct word is returned with no duplicate or skipped byte.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences the single byte-wide RAM/UART bus between the
// instruction cache (32-bit fetches) and the load/store buffer (1/2/4-byte
// loads and stores).
//
// Handshake: a requester raises its level request (IC_S / LSB_S) with its
// fields and holds it until the matching one-cycle success pulse. Fields are
// latched at grant, so later changes on the inputs are ignored. The success
// pulse is the only acceptance/completion event. There is no separate ready.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   rdy               low = freeze all state, mem_wr forced to 0
//   clr               pipeline flush (aborts reads, never aborts writes)
//   io_buffer_full    UART tx buffer full, holds I/O write beats
//   mem_din           RAM read byte, valid one cycle after its address
//   mem_dout/mem_a/mem_wr  byte bus write data / address / write strobe
//   IC_S/IC_pos/IC_success/IC_value            ICache fetch port
//   LSB_S/LSB_type/LSB_pos/LSB_len/LSB_result/
//   LSB_success/LSB_value                      load/store buffer port
//   dbg_state, dbg_starve   FSM state and anti-starvation counter
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int IO_GAP       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        IC_S,
  input  logic [31:0] IC_pos,
  output logic        IC_success,
  output logic [31:0] IC_value,
  input  logic        LSB_S,
  input  logic        LSB_type,
  input  logic [31:0] LSB_pos,
  input  logic [2:0]  LSB_len,
  input  logic [31:0] LSB_result,
  output logic        LSB_success,
  output logic [31:0] LSB_value,
  output logic [2:0]  dbg_state,
  output logic [7:0]  dbg_starve
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WRITE  = 3'd2,
    DONE   = 3'd3,
    IOWAIT = 3'd4
  } state_t;

  state_t      state;
  logic [7:0]  starve;
  logic [7:0]  gap_cnt;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] rd_data;
  logic [31:0] rd_next;
  logic [1:0]  last_q;     // index of the final byte of the transaction
  logic [1:0]  a_idx;      // byte index currently on mem_a
  logic [1:0]  r_idx;      // next byte index to capture from mem_din
  logic        pend;       // mem_din this cycle answers the previous address
  logic        issuing;    // mem_a still carries an unissued read beat
  logic        stalled;    // previous cycle had rdy=0
  logic        owner_ic;
  logic        is_write;
  logic        io_q;
  logic        wr_q;
  logic        ic_succ_q;
  logic        lsb_succ_q;

  logic        ic_req;
  logic        lsb_req;
  logic        ic_win;
  logic        lsb_win;
  logic        beat_go;
  logic [31:0] grant_pos;
  logic [1:0]  lsb_last;

  // A pulse is only visible in a running cycle; a flush hides read results.
  assign IC_success  = ic_succ_q && rdy && !clr;
  assign LSB_success = lsb_succ_q && rdy && !(clr && !is_write);

  // An I/O beat is held (not written, not advanced) while the UART is full.
  assign mem_wr  = wr_q && rdy && !(io_q && io_buffer_full);
  assign beat_go = (state == WRITE) && mem_wr;

  assign dbg_state  = state;
  assign dbg_starve = starve;

  always_comb begin
    ic_req    = IC_S && !IC_success;
    lsb_req   = LSB_S && !LSB_success;
    ic_win    = ic_req && (!lsb_req || (starve == 8'(STARVE_LIMIT)));
    lsb_win   = lsb_req && !ic_win;
    grant_pos = ic_win ? IC_pos : LSB_pos;
    if (LSB_len == 3'd0)
      lsb_last = 2'd0;
    else if (LSB_len >= 3'd4)
      lsb_last = 2'd3;
    else
      lsb_last = 2'(LSB_len - 3'd1);
    rd_next = rd_data;
    rd_next[{r_idx, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve     <= '0;
      gap_cnt    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rd_data    <= '0;
      last_q     <= '0;
      a_idx      <= '0;
      r_idx      <= '0;
      pend       <= 1'b0;
      issuing    <= 1'b0;
      stalled    <= 1'b0;
      owner_ic   <= 1'b0;
      is_write   <= 1'b0;
      io_q       <= 1'b0;
      wr_q       <= 1'b0;
      ic_succ_q  <= 1'b0;
      lsb_succ_q <= 1'b0;
      mem_a      <= '0;
      mem_dout   <= '0;
      IC_value   <= '0;
      LSB_value  <= '0;
    end else if (!rdy) begin
      stalled <= 1'b1;
    end else begin
      stalled    <= 1'b0;
      ic_succ_q  <= 1'b0;
      lsb_succ_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!clr && (ic_win || lsb_win)) begin
            owner_ic <= ic_win;
            is_write <= lsb_win && LSB_type;
            addr_q   <= grant_pos;
            mem_a    <= grant_pos;
            io_q     <= (grant_pos[17:16] == 2'b11);
            last_q   <= ic_win ? 2'd3 : lsb_last;
            data_q   <= LSB_result;
            rd_data  <= '0;
            a_idx    <= '0;
            r_idx    <= '0;
            pend     <= 1'b0;
            issuing  <= 1'b1;
            if (lsb_win && LSB_type) begin
              mem_dout <= LSB_result[7:0];
              wr_q     <= 1'b1;
              state    <= WRITE;
            end else begin
              state <= READ;
            end
            if (ic_win)
              starve <= '0;
            else if (ic_req && (starve != 8'(STARVE_LIMIT)))
              starve <= starve + 8'd1;
          end
        end

        READ: begin
          if (clr) begin
            state   <= IDLE;
            pend    <= 1'b0;
            issuing <= 1'b0;
          end else if (stalled) begin
            // mem_din is not trusted across a stall: restart from the oldest
            // byte not yet captured.
            a_idx   <= r_idx;
            mem_a   <= addr_q + 32'(r_idx);
            pend    <= 1'b0;
            issuing <= 1'b1;
          end else begin
            if (issuing) begin
              pend <= 1'b1;
              if (a_idx == last_q) begin
                issuing <= 1'b0;
              end else begin
                a_idx <= a_idx + 2'd1;
                mem_a <= addr_q + 32'(a_idx) + 32'd1;
              end
            end else begin
              pend <= 1'b0;
            end
            if (pend) begin
              rd_data <= rd_next;
              r_idx   <= r_idx + 2'd1;
              if (r_idx == last_q) begin
                state <= DONE;
                pend  <= 1'b0;
                if (owner_ic) begin
                  IC_value  <= rd_next;
                  ic_succ_q <= 1'b1;
                end else begin
                  LSB_value  <= rd_next;
                  lsb_succ_q <= 1'b1;
                end
              end
            end
          end
        end

        WRITE: begin
          if (beat_go) begin
            if (a_idx == last_q) begin
              wr_q <= 1'b0;
              if (io_q && (IO_GAP > 0)) begin
                state   <= IOWAIT;
                gap_cnt <= 8'd1;
              end else begin
                state      <= DONE;
                lsb_succ_q <= 1'b1;
              end
            end else begin
              a_idx    <= a_idx + 2'd1;
              mem_a    <= addr_q + 32'(a_idx) + 32'd1;
              mem_dout <= data_q[15:8];
              data_q   <= data_q >> 8;
            end
          end
        end

        IOWAIT: begin
          if (gap_cnt >= 8'(IO_GAP)) begin
            state      <= DONE;
            lsb_succ_q <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. A small byte RAM model answers mem_a one
// cycle later and records every write beat. Each test task drives one
// scenario and compares against hand-computed values.
module tb_mem_arbiter;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_IOWAIT = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        clr = 1'b0;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        IC_S = 1'b0;
  logic [31:0] IC_pos = 32'h0;
  logic        IC_success;
  logic [31:0] IC_value;
  logic        LSB_S = 1'b0;
  logic        LSB_type = 1'b0;
  logic [31:0] LSB_pos = 32'h0;
  logic [2:0]  LSB_len = 3'd4;
  logic [31:0] LSB_result = 32'h0;
  logic        LSB_success;
  logic [31:0] LSB_value;
  logic [2:0]  dbg_state;
  logic [7:0]  dbg_starve;

  int errors = 0;
  int checks = 0;

  logic [7:0]  ram [0:4095];
  logic [39:0] wr_log[$];
  logic [39:0] exp_q[$];

  mem_arbiter #(.STARVE_LIMIT(4), .IO_GAP(1)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .IC_S(IC_S), .IC_pos(IC_pos), .IC_success(IC_success), .IC_value(IC_value),
    .LSB_S(LSB_S), .LSB_type(LSB_type), .LSB_pos(LSB_pos), .LSB_len(LSB_len),
    .LSB_result(LSB_result), .LSB_success(LSB_success), .LSB_value(LSB_value),
    .dbg_state(dbg_state), .dbg_starve(dbg_starve)
  );

  // ---------------- clock / RAM model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_din <= ram[mem_a[11:0]];
    if (mem_wr) begin
      wr_log.push_back({mem_a, mem_dout});
      if (mem_a[17:16] != 2'b11) ram[mem_a[11:0]] <= mem_dout;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver ----------------
  // Issues one LSB request; cyc is the cycle of LSB_success after grant
  // (0 if it never came).
  task automatic run_lsb(input logic typ, input logic [31:0] pos, input logic [2:0] len,
                         input logic [31:0] data, output int cyc, output logic [31:0] val);
    cyc = 0;
    val = 32'h0;
    @(negedge clk);
    LSB_S = 1'b1; LSB_type = typ; LSB_pos = pos; LSB_len = len; LSB_result = data;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (LSB_success) begin
        cyc = k;
        val = LSB_value;
        break;
      end
    end
    LSB_S = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a: got %h exp 0", mem_a); end
    checks++; if (mem_dout !== 8'h0) begin errors++; $display("FAIL reset_mem_dout: got %h exp 0", mem_dout); end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b exp 0", mem_wr); end
    checks++; if (IC_success !== 1'b0 || LSB_success !== 1'b0) begin errors++; $display("FAIL reset_success: got %b%b exp 00", IC_success, LSB_success); end
    checks++; if (IC_value !== 32'h0 || LSB_value !== 32'h0) begin errors++; $display("FAIL reset_values: got %h %h exp 0 0", IC_value, LSB_value); end
    checks++; if (dbg_state !== S_IDLE || dbg_starve !== 8'd0) begin errors++; $display("FAIL reset_state: got %0d/%0d exp 0/0", dbg_state, dbg_starve); end
    rst = 1'b0;
  endtask

  task automatic test_ic_fetch();
    logic [31:0] a_seen [1:8];
    logic        wr_seen [1:8];
    logic        succ_seen [1:8];
    logic [31:0] val = 32'h0;
    @(negedge clk);
    IC_pos = 32'h100; IC_S = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      a_seen[k] = mem_a; wr_seen[k] = mem_wr; succ_seen[k] = IC_success;
      if (IC_success) begin val = IC_value; IC_S = 1'b0; end
    end
    IC_S = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (a_seen[k] !== 32'h100 + 32'(k - 1) || wr_seen[k] !== 1'b0) begin
        errors++; $display("FAIL fetch_addr c%0d: got %h wr=%b exp %h wr=0", k, a_seen[k], wr_seen[k], 32'h100 + 32'(k - 1));
      end
    end
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (succ_seen[k] !== (k == 6)) begin
        errors++; $display("FAIL fetch_pulse c%0d: got %b exp %b", k, succ_seen[k], (k == 6));
      end
    end
    checks++; if (val !== 32'h00000013) begin errors++; $display("FAIL fetch_value: got %h exp 00000013", val); end

    // Second fetch checks little-endian assembly of all four bytes.
    val = 32'h0;
    begin
      int cyc = 0;
      @(negedge clk);
      IC_pos = 32'h104; IC_S = 1'b1;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (IC_success) begin cyc = k; val = IC_value; break; end
      end
      IC_S = 1'b0;
      checks++; if (cyc != 6) begin errors++; $display("FAIL fetch2_cycle: got %0d exp 6", cyc); end
    end
    checks++; if (val !== 32'h11223344) begin errors++; $display("FAIL fetch2_value: got %h exp 11223344", val); end
  endtask

  task automatic test_store_load();
    int cyc;
    logic [31:0] val;
    logic [39:0] got;
    wr_log.delete();
    exp_q.delete();
    exp_q.push_back({32'h200, 8'hEF});
    exp_q.push_back({32'h201, 8'hBE});
    exp_q.push_back({32'h202, 8'hAD});
    exp_q.push_back({32'h203, 8'hDE});
    run_lsb(1'b1, 32'h200, 3'd4, 32'hDEADBEEF, cyc, val);
    checks++; if (cyc != 5) begin errors++; $display("FAIL sw_cycle: got %0d exp 5", cyc); end
    checks++; if (wr_log.size() != 4) begin errors++; $display("FAIL sw_beats: got %0d exp 4", wr_log.size()); end
    while (exp_q.size() > 0) begin
      logic [39:0] e;
      e = exp_q.pop_front();
      got = (wr_log.size() > 0) ? wr_log.pop_front() : 40'h0;
      checks++; if (got !== e) begin errors++; $display("FAIL sw_beat: got %h exp %h", got, e); end
    end
    run_lsb(1'b0, 32'h202, 3'd2, 32'h0, cyc, val);
    checks++; if (cyc != 4) begin errors++; $display("FAIL lh_cycle: got %0d exp 4", cyc); end
    checks++; if (val !== 32'h0000DEAD) begin errors++; $display("FAIL lh_value: got %h exp 0000DEAD", val); end
    run_lsb(1'b0, 32'h203, 3'd1, 32'h0, cyc, val);
    checks++; if (cyc != 3 || val !== 32'h000000DE) begin errors++; $display("FAIL lb_value: got %h@%0d exp 000000DE@3", val, cyc); end
  endtask

  task automatic test_io_write();
    logic       wr_seen [1:8];
    logic       succ_seen [1:8];
    logic [2:0] st_seen [1:8];
    logic [39:0] got;
    wr_log.delete();
    @(negedge clk);
    LSB_S = 1'b1; LSB_type = 1'b1; LSB_pos = 32'h30000; LSB_len = 3'd1; LSB_result = 32'h41;
    io_buffer_full = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      wr_seen[k] = mem_wr; succ_seen[k] = LSB_success; st_seen[k] = dbg_state;
      if (LSB_success) LSB_S = 1'b0;
      if (k == 3) begin @(posedge clk); #1 io_buffer_full = 1'b0; end
    end
    LSB_S = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (wr_seen[k] !== (k == 4)) begin errors++; $display("FAIL io_wr c%0d: got %b exp %b", k, wr_seen[k], (k == 4)); end
    end
    checks++; if (st_seen[5] !== S_IOWAIT) begin errors++; $display("FAIL io_wait_state: got %0d exp 4", st_seen[5]); end
    checks++; if (succ_seen[6] !== 1'b1 || succ_seen[5] !== 1'b0) begin errors++; $display("FAIL io_pulse: got c5=%b c6=%b exp 0 1", succ_seen[5], succ_seen[6]); end
    checks++; if (wr_log.size() != 1) begin errors++; $display("FAIL io_beats: got %0d exp 1", wr_log.size()); end
    got = (wr_log.size() > 0) ? wr_log.pop_front() : 40'h0;
    checks++; if (got !== {32'h30000, 8'h41}) begin errors++; $display("FAIL io_beat: got %h exp 0003000041", got); end
  endtask

  task automatic test_clr();
    int cyc;
    int pulses;
    logic [31:0] val;
    // clr in cycle 2 of a fetch
    @(negedge clk);
    IC_pos = 32'h100; IC_S = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (IC_success) pulses++;
      if (k == 3) begin
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL clr_fetch_idle: got %0d exp 0", dbg_state); end
      end
      if (k == 1) begin @(posedge clk); #1 clr = 1'b1; IC_S = 1'b0; end
      if (k == 2) begin @(posedge clk); #1 clr = 1'b0; end
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL clr_fetch_pulse: got %0d exp 0", pulses); end

    // clr in cycles 2-3 of a store does not abort it
    wr_log.delete();
    cyc = 0;
    @(negedge clk);
    LSB_S = 1'b1; LSB_type = 1'b1; LSB_pos = 32'h210; LSB_len = 3'd4; LSB_result = 32'hCAFEF00D;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (LSB_success && cyc == 0) begin cyc = k; LSB_S = 1'b0; end
      if (k == 1) begin @(posedge clk); #1 clr = 1'b1; end
      if (k == 3) begin @(posedge clk); #1 clr = 1'b0; end
    end
    LSB_S = 1'b0;
    checks++; if (cyc != 5) begin errors++; $display("FAIL clr_store_cycle: got %0d exp 5", cyc); end
    checks++; if (wr_log.size() != 4) begin errors++; $display("FAIL clr_store_beats: got %0d exp 4", wr_log.size()); end
    run_lsb(1'b0, 32'h210, 3'd4, 32'h0, cyc, val);
    checks++; if (val !== 32'hCAFEF00D) begin errors++; $display("FAIL clr_store_readback: got %h exp CAFEF00D", val); end

    // clr during DONE of a byte load suppresses the pulse
    pulses = 0;
    @(negedge clk);
    LSB_S = 1'b1; LSB_type = 1'b0; LSB_pos = 32'h200; LSB_len = 3'd1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (LSB_success) pulses++;
      if (k == 2) begin @(posedge clk); #1 clr = 1'b1; LSB_S = 1'b0; end
      if (k == 3) begin @(posedge clk); #1 clr = 1'b0; end
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL clr_done_pulse: got %0d exp 0", pulses); end
  endtask

  task automatic test_rdy_stall();
    int cyc;
    logic [31:0] val;
    // 4-byte load from 0x300 with rdy low in cycles 3 and 4
    cyc = 0; val = 32'h0;
    @(negedge clk);
    LSB_S = 1'b1; LSB_type = 1'b0; LSB_pos = 32'h300; LSB_len = 3'd4;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 3 || k == 4) begin
        checks++;
        if (mem_a !== 32'h302 || mem_wr !== 1'b0 || dbg_state !== S_READ) begin
          errors++; $display("FAIL stall_hold c%0d: got a=%h wr=%b st=%0d exp a=302 wr=0 st=1", k, mem_a, mem_wr, dbg_state);
        end
      end
      if (LSB_success) begin cyc = k; val = LSB_value; break; end
      if (k == 2) begin @(posedge clk); #1 rdy = 1'b0; end
      if (k == 4) begin @(posedge clk); #1 rdy = 1'b1; end
    end
    LSB_S = 1'b0;
    rdy = 1'b1;
    checks++; if (cyc == 0 || val !== 32'h12345678) begin errors++; $display("FAIL stall_load: got %h@%0d exp 12345678", val, cyc); end

    // 4-byte store with rdy low in cycle 2
    wr_log.delete();
    cyc = 0;
    @(negedge clk);
    LSB_S = 1'b1; LSB_type = 1'b1; LSB_pos = 32'h310; LSB_len = 3'd4; LSB_result = 32'h04030201;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 2) begin
        checks++;
        if (mem_wr !== 1'b0 || mem_a !== 32'h311) begin
          errors++; $display("FAIL stall_store_hold: got wr=%b a=%h exp wr=0 a=311", mem_wr, mem_a);
        end
      end
      if (LSB_success) begin cyc = k; break; end
      if (k == 1) begin @(posedge clk); #1 rdy = 1'b0; end
      if (k == 2) begin @(posedge clk); #1 rdy = 1'b1; end
    end
    LSB_S = 1'b0;
    rdy = 1'b1;
    checks++; if (cyc != 6) begin errors++; $display("FAIL stall_store_cycle: got %0d exp 6", cyc); end
    checks++; if (wr_log.size() != 4) begin errors++; $display("FAIL stall_store_beats: got %0d exp 4", wr_log.size()); end
    run_lsb(1'b0, 32'h310, 3'd4, 32'h0, cyc, val);
    checks++; if (val !== 32'h04030201) begin errors++; $display("FAIL stall_store_readback: got %h exp 04030201", val); end
  endtask

  task automatic test_back_to_back();
    int lsb_n = 0;
    int lsb_at_ic = -1;
    logic first_is_lsb = 1'b0;
    logic any_pulse = 1'b0;
    logic [7:0] starve_max = 8'd0;
    logic [31:0] icv = 32'h0;
    @(negedge clk);
    IC_pos = 32'h104; IC_S = 1'b1;
    LSB_S = 1'b1; LSB_type = 1'b0; LSB_pos = 32'h300; LSB_len = 3'd4;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (dbg_starve > starve_max) starve_max = dbg_starve;
      if (!any_pulse && (LSB_success || IC_success)) begin any_pulse = 1'b1; first_is_lsb = LSB_success; end
      if (LSB_success) lsb_n++;
      if (IC_success) begin lsb_at_ic = lsb_n; icv = IC_value; break; end
    end
    IC_S = 1'b0; LSB_S = 1'b0;
    @(negedge clk);
    checks++; if (first_is_lsb !== 1'b1) begin errors++; $display("FAIL b2b_first_winner: got ic exp lsb"); end
    checks++; if (lsb_at_ic != 4) begin errors++; $display("FAIL b2b_lsb_grants: got %0d exp 4", lsb_at_ic); end
    checks++; if (starve_max !== 8'd4) begin errors++; $display("FAIL b2b_starve_max: got %0d exp 4", starve_max); end
    checks++; if (dbg_starve !== 8'd0) begin errors++; $display("FAIL b2b_starve_clear: got %0d exp 0", dbg_starve); end
    checks++; if (icv !== 32'h11223344) begin errors++; $display("FAIL b2b_ic_value: got %h exp 11223344", icv); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    @(negedge clk);
    IC_pos = 32'h100; IC_S = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 2) begin @(posedge clk); #1 rst = 1'b1; end
      if (k == 3) begin @(posedge clk); #1 rst = 1'b0; IC_S = 1'b0; end
    end
    @(negedge clk);
    checks++; if (dbg_state !== S_IDLE || mem_a !== 32'h0) begin errors++; $display("FAIL rst_mid_state: got st=%0d a=%h exp 0 0", dbg_state, mem_a); end
    checks++; if (IC_value !== 32'h0 || LSB_value !== 32'h0) begin errors++; $display("FAIL rst_mid_values: got %h %h exp 0 0", IC_value, LSB_value); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (IC_success || LSB_success || mem_wr) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rst_mid_pulse: got %0d exp 0", pulses); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13;
    ram[12'h104] = 8'h44; ram[12'h105] = 8'h33; ram[12'h106] = 8'h22; ram[12'h107] = 8'h11;
    ram[12'h300] = 8'h78; ram[12'h301] = 8'h56; ram[12'h302] = 8'h34; ram[12'h303] = 8'h12;
    test_reset();
    test_ic_fetch();
    test_store_load();
    test_io_write();
    test_clr();
    test_rdy_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
